tt_um_hoene_frame_transmitter: RTL
==================================

Name: tt_um_hoene_frame_transmitter

Overview:
Controller-side serializer for the smart-LED chain. It turns 30-bit LED words into the bit stream that the chain's protocol-select stage receives. Each frame is a start bit, 30 data bits and a parity bit, delivered as data, bit-strobe and sync signals. Its outputs feed the Manchester encoder in place of the decoder-side signals, so one chip can generate test streams for downstream LEDs.

Parameters:
BIT_PERIOD  16  clocks per bit; minimum 2
GAP_BITS  4  bit periods with sync low after a burst; minimum 1
CNT_W  8  width of the frame counter

Ports:
clk  in  1  global clock
rst  in  1  asynchronous, active-high reset
data_in  in  30  LED word; bit 29 is sent first
data_valid  in  1  data_in is valid
data_last  in  1  qualifies data_in: final frame of the burst
data_ready  out  1  transmitter accepts data_in this cycle
out_data  out  1  serial bit; held stable for the whole bit period
out_clk  out  1  one-cycle strobe on the first clock of every bit period
out_sync  out  1  high for the complete burst
busy  out  1  state is not IDLE
frame_count  out  CNT_W  frames sent in the current burst; saturates at all-ones
underrun_err  out  1  one-cycle pulse when a non-last frame ends with no data_valid

Behaviour:
- Reset: asynchronous, active-high. It forces all outputs to 0, state to IDLE and all counters to 0.
  - Reset asserted mid-frame truncates the frame immediately, with out_sync low in the same cycle.
- Frame layout, 32 bits: start bit 1, then data_in[29] down to data_in[0], then parity.
  - parity = 1 XOR (XOR-reduce of data_in), so the XOR of all 32 bits is 0.
- The accepted word is latched into a 30-bit shift register. data_in may change after the handshake.
- States:
  - IDLE: data_ready=1. On data_valid, latch word and last flag, clear frame_count, go to SEND. The start bit's out_clk is asserted on the next cycle (latency 1). out_sync rises in that same cycle.
  - SEND: a bit timer counts 0 to BIT_PERIOD-1. At count 0, out_clk=1 and out_data takes the next bit. Bit index runs 0 to 31.
    - data_ready=1 only during the whole bit-31 period, and only if the current frame is not last.
    - A handshake there preloads the next word. The next start bit then follows the last parity cycle with no gap, out_sync stays high, and frame_count increments.
    - At the end of bit 31 with last set: frame_count increments, go to GAP.
    - At the end of bit 31 with last clear and no preload: underrun_err pulses for 1 cycle, then go to GAP.
  - GAP: out_sync=0, out_data=0, out_clk=0 for GAP_BITS*BIT_PERIOD cycles, then go to IDLE. data_ready=0.
- frame_count increments at the end of each completed parity bit. It saturates at 2^CNT_W-1, never wraps, and holds its value through GAP and IDLE until the next burst starts.
- out_clk is never asserted while out_sync=0.
- If data_valid and data_last are both high in IDLE, exactly one frame is sent.
- If data_valid is high in GAP, it is ignored (not consumed) until IDLE.

Decomposition:
- Shared include/package `tt_um_hoene_smartled_defs`:
  - FRAME_BITS=32, DATA_BITS=30, START_BIT=1'b1
  - state encodings IDLE/SEND/GAP
  - the parity function (reused by the receive side)
- One sub-module, tt_um_hoene_bit_timer: BIT_PERIOD counter producing bit_start and bit_end strobes, cleared by an enable. It is reused for the GAP timing.

Test Plan (BIT_PERIOD=4, GAP_BITS=4):
- Single frame: data_in=30'h2AAAAAAA with last=1 in IDLE.
  - out_clk pulses 32 times, 4 cycles apart.
  - Bits are 1,1,0,1,0,…,0 with parity 0.
  - out_sync high for exactly 128 cycles, then low for 16 cycles; frame_count=1.
- Parity: data_in=0 gives parity bit 1; data_in=30'h00000001 gives parity bit 0.
  - In both cases the XOR of all 32 captured bits is 0.
- Back-to-back: three words, the third with last=1, each presented during bit 31.
  - out_sync is continuous for 384 cycles.
  - Start bits fall at cycles 1, 129 and 257 relative to the first accept; frame_count=3.
- Underrun: two-frame burst, data_valid held low during the first frame's bit 31.
  - underrun_err pulses once at the end of bit 31.
  - out_sync drops, GAP follows, and frame_count=1.
- Reset mid-frame: assert rst during bit 10.
  - All outputs are 0 in the same cycle.
  - After release, IDLE with data_ready=1, and a new frame starts cleanly.
- Saturation with CNT_W=2: five-frame burst ends with frame_count=3.

Source files
------------

// File: rtl/tt_um_hoene_smartled_defs.sv
// Shared definitions for the smart-LED chain: frame geometry, transmitter
// state encoding and the frame parity rule used by both link directions.
package tt_um_hoene_smartled_defs;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned DATA_BITS  = 30;
    localparam logic        START_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

    // Chosen so that the XOR over the whole 32-bit frame is zero.
    function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
        return 1'b1 ^ (^d);
    endfunction

endpackage

// File: rtl/tt_um_hoene_bit_timer.sv
// Free-running bit-period counter; held at zero while disabled so the first
// enabled cycle is always a bit start.
module tt_um_hoene_bit_timer #(
    parameter int unsigned BIT_PERIOD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_start,
    output logic bit_end
);

    localparam int unsigned CW = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_start = en && (count == '0);
    assign bit_end   = en && (count == LAST);

endmodule

// File: rtl/tt_um_hoene_frame_transmitter.sv
// Frame serializer for the smart-LED chain: start bit, 30 data bits MSB first,
// parity; back-to-back frames within a burst, then a sync-low gap.
module tt_um_hoene_frame_transmitter
    import tt_um_hoene_smartled_defs::*;
#(
    parameter int unsigned BIT_PERIOD = 16,
    parameter int unsigned GAP_BITS   = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    input  logic                 data_last,
    output logic                 data_ready,
    output logic                 out_data,
    output logic                 out_clk,
    output logic                 out_sync,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_count,
    output logic                 underrun_err
);

    localparam int unsigned GW = $clog2(GAP_BITS) + 1;
    localparam logic [4:0]    LAST_BIT = 5'(FRAME_BITS - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 last_q;
    logic                 pre_parity_q;
    logic                 pre_last_q;
    logic                 preloaded_q;
    logic                 armed_q;
    logic [4:0]           bit_idx;
    logic [GW-1:0]        gap_idx;
    logic                 bit_start;
    logic                 bit_end;
    logic                 accept;
    logic                 in_last_bit;

    tt_um_hoene_bit_timer #(.BIT_PERIOD(BIT_PERIOD)) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (state != IDLE),
        .bit_start (bit_start),
        .bit_end   (bit_end)
    );

    assign in_last_bit = (state == SEND) && (bit_idx == LAST_BIT);
    // armed_q keeps data_ready low while reset is held and stays low until the
    // first clock after release.
    assign data_ready  = armed_q && ((state == IDLE) ||
                                     (in_last_bit && !last_q && !preloaded_q));
    assign accept      = data_valid && data_ready;
    assign out_sync    = (state == SEND);
    assign out_clk     = (state == SEND) && bit_start;
    assign busy        = (state != IDLE);

    always_comb begin
        out_data = 1'b0;
        if (state == SEND) begin
            if (bit_idx == '0)
                out_data = START_BIT;
            else if (bit_idx == LAST_BIT)
                out_data = parity_q;
            else
                out_data = shift_q[DATA_BITS-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            last_q       <= 1'b0;
            pre_parity_q <= 1'b0;
            pre_last_q   <= 1'b0;
            preloaded_q  <= 1'b0;
            armed_q      <= 1'b0;
            bit_idx      <= '0;
            gap_idx      <= '0;
            frame_count  <= '0;
            underrun_err <= 1'b0;
        end else begin
            armed_q      <= 1'b1;
            underrun_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_q     <= data_in;
                        parity_q    <= frame_parity(data_in);
                        last_q      <= data_last;
                        preloaded_q <= 1'b0;
                        frame_count <= '0;
                        bit_idx     <= '0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    // The shift register is idle during the parity bit, so a
                    // preload lands there directly; parity/last wait aside.
                    if (accept) begin
                        shift_q      <= data_in;
                        pre_parity_q <= frame_parity(data_in);
                        pre_last_q   <= data_last;
                        preloaded_q  <= 1'b1;
                    end
                    if (bit_end) begin
                        if (bit_idx != LAST_BIT) begin
                            bit_idx <= bit_idx + 5'd1;
                            if (bit_idx != '0)
                                shift_q <= shift_q << 1;
                        end else begin
                            if (frame_count != '1)
                                frame_count <= frame_count + CNT_W'(1);
                            bit_idx <= '0;
                            if (preloaded_q || accept) begin
                                preloaded_q <= 1'b0;
                                parity_q    <= accept ? frame_parity(data_in) : pre_parity_q;
                                last_q      <= accept ? data_last : pre_last_q;
                            end else begin
                                underrun_err <= !last_q;
                                gap_idx      <= '0;
                                state        <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (bit_end) begin
                        if (gap_idx == LAST_GAP)
                            state <= IDLE;
                        else
                            gap_idx <= gap_idx + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
